// File: rtl/pf_vf_mux_pkg.sv
// pf_vf_mux_pkg
// PF/VF routing table entry, wildcard and PCIe SS header offsets.
package pf_vf_mux_pkg;

  localparam int PF_W   = 3;
  localparam int VF_W   = 11;
  localparam int PORT_W = 8;

  localparam int HDR_PF_LSB = 160;
  localparam int HDR_VF_LSB = 163;
  localparam int HDR_VA_BIT = 174;

  localparam logic [PF_W-1:0] PF_ANY = '1;
  localparam logic [VF_W-1:0] VF_ANY = '1;

  typedef struct packed {
    logic [PF_W-1:0]   pf;
    logic [VF_W-1:0]   vf;
    logic              vf_active;
    logic [PORT_W-1:0] pfvf_port;
  } t_pfvf_rtable_entry;

  localparam t_pfvf_rtable_entry RT_PF0 =
    '{pf: 3'd0, vf: VF_ANY, vf_active: 1'b0, pfvf_port: 8'd0};
  localparam t_pfvf_rtable_entry RT_PF1 =
    '{pf: 3'd1, vf: VF_ANY, vf_active: 1'b0, pfvf_port: 8'd1};
  localparam t_pfvf_rtable_entry RT_ANY_PF =
    '{pf: PF_ANY, vf: VF_ANY, vf_active: 1'b0, pfvf_port: 8'd0};
  localparam t_pfvf_rtable_entry RT_ANY_VF =
    '{pf: PF_ANY, vf: VF_ANY, vf_active: 1'b1, pfvf_port: 8'd0};

  localparam int DEFAULT_RTABLE_N = 4;
  localparam t_pfvf_rtable_entry [DEFAULT_RTABLE_N-1:0]
    DEFAULT_RTABLE = {RT_ANY_VF, RT_ANY_PF, RT_PF1, RT_PF0};

  function automatic logic entry_hit(
    input t_pfvf_rtable_entry e,
    input logic [PF_W-1:0]    pf,
    input logic [VF_W-1:0]    vf,
    input logic               va
  );
    return ((e.pf == PF_ANY) || (e.pf == pf)) &&
           ((e.vf == VF_ANY) || (e.vf == vf)) &&
           (e.vf_active == va);
  endfunction

endpackage

// File: rtl/pfvf_rtable_match.sv
// pfvf_rtable_match
// Table match and priority select: one-hot of the lowest matching entry.
module pfvf_rtable_match
  import pf_vf_mux_pkg::*;
#(
  parameter int N = DEFAULT_RTABLE_N,
  parameter t_pfvf_rtable_entry [N-1:0] TABLE = DEFAULT_RTABLE
) (
  input  logic [PF_W-1:0] pf_i,
  input  logic [VF_W-1:0] vf_i,
  input  logic            va_i,
  output logic [N-1:0]    first_o
);

  logic taken;

  // Walk from entry 0 upward; the first hit masks all later ones.
  always_comb begin
    taken   = 1'b0;
    first_o = '0;
    for (int i = 0; i < N; i++) begin
      if (!taken && entry_hit(TABLE[i], pf_i, vf_i, va_i)) begin
        first_o[i] = 1'b1;
        taken      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pfvf_route_lookup.sv
// pfvf_route_lookup
// Two-stage elastic AXI-S stage tagging each TLP with its PF/VF MUX port.
module pfvf_route_lookup
  import pf_vf_mux_pkg::*;
#(
  parameter int NUM_PORT = 2,
  parameter int NUM_RTABLE_ENTRIES = NUM_PORT + 2,
  parameter t_pfvf_rtable_entry [NUM_RTABLE_ENTRIES-1:0]
    PFVF_ROUTING_TABLE = DEFAULT_RTABLE,
  parameter int DATA_W = 512,
  localparam int NID_WIDTH = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_tvalid,
  output logic                 rx_tready,
  input  logic [DATA_W-1:0]    rx_tdata,
  input  logic [DATA_W/8-1:0]  rx_tkeep,
  input  logic                 rx_tlast,
  output logic                 tx_tvalid,
  input  logic                 tx_tready,
  output logic [DATA_W-1:0]    tx_tdata,
  output logic [DATA_W/8-1:0]  tx_tkeep,
  output logic                 tx_tlast,
  output logic [NID_WIDTH-1:0] tx_port_id,
  output logic                 tx_miss,
  output logic [15:0]          miss_cnt
);

  localparam int NE = NUM_RTABLE_ENTRIES;

  logic                 rx_fire;
  logic                 s1_ready;
  logic                 s2_ready;
  logic                 s2_load;
  logic                 tx_fire;
  logic                 in_pkt_q;
  logic                 in_pkt_d;
  logic [NE-1:0]        first_hit;

  logic                 s1_valid_q;
  logic                 s1_sop_q;
  logic                 s1_last_q;
  logic [DATA_W-1:0]    s1_data_q;
  logic [DATA_W/8-1:0]  s1_keep_q;
  logic [NE-1:0]        s1_hit_q;

  logic [PORT_W-1:0]    enc_port;
  logic                 enc_miss;

  logic                 tx_valid_q;
  logic                 tx_sop_q;
  logic                 tx_last_q;
  logic                 tx_miss_q;
  logic [DATA_W-1:0]    tx_data_q;
  logic [DATA_W/8-1:0]  tx_keep_q;
  logic [NID_WIDTH-1:0] tx_port_q;
  logic [15:0]          miss_cnt_q;
  logic [15:0]          miss_cnt_d;

  assign s2_ready  = !tx_valid_q || tx_tready;
  assign s1_ready  = !s1_valid_q || s2_ready;
  assign rx_tready = rst_n && s1_ready;
  assign rx_fire   = rx_tvalid && rx_tready;
  assign s2_load   = s1_valid_q && s2_ready;
  assign tx_fire   = tx_valid_q && tx_tready;

  pfvf_rtable_match #(
    .N     (NE),
    .TABLE (PFVF_ROUTING_TABLE)
  ) u_match (
    .pf_i    (rx_tdata[HDR_PF_LSB +: PF_W]),
    .vf_i    (rx_tdata[HDR_VF_LSB +: VF_W]),
    .va_i    (rx_tdata[HDR_VA_BIT]),
    .first_o (first_hit)
  );

  // Packet tracking: the next accepted beat after tlast is a SOP.
  always_comb begin
    in_pkt_d = in_pkt_q;
    if (rx_fire) in_pkt_d = !rx_tlast;
  end

  // Stage 1: capture beat, SOP flag and first-hit vector.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      in_pkt_q   <= 1'b0;
    end else begin
      in_pkt_q <= in_pkt_d;
      if (s1_ready) s1_valid_q <= rx_tvalid;
      if (rx_fire) begin
        s1_data_q <= rx_tdata;
        s1_keep_q <= rx_tkeep;
        s1_last_q <= rx_tlast;
        s1_sop_q  <= !in_pkt_q;
        s1_hit_q  <= first_hit;
      end
    end
  end

  // One-hot to port ID; no hit means port 0 and a miss.
  always_comb begin
    enc_port = '0;
    for (int i = 0; i < NE; i++) begin
      if (s1_hit_q[i]) enc_port |= PFVF_ROUTING_TABLE[i].pfvf_port;
    end
    enc_miss = ~|s1_hit_q;
  end

  // Stage 2: route only changes when a SOP beat is loaded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_valid_q <= 1'b0;
      tx_sop_q   <= 1'b0;
      tx_port_q  <= '0;
      tx_miss_q  <= 1'b0;
    end else begin
      if (s2_ready) tx_valid_q <= s1_valid_q;
      if (s2_load) begin
        tx_data_q <= s1_data_q;
        tx_keep_q <= s1_keep_q;
        tx_last_q <= s1_last_q;
        tx_sop_q  <= s1_sop_q;
        if (s1_sop_q) begin
          tx_port_q <= enc_port[NID_WIDTH-1:0];
          tx_miss_q <= enc_miss;
        end
      end
    end
  end

  // Count missed packets as their SOP beat leaves, saturating.
  always_comb begin
    miss_cnt_d = miss_cnt_q;
    if (tx_fire && tx_sop_q && tx_miss_q && (miss_cnt_q != 16'hFFFF))
      miss_cnt_d = miss_cnt_q + 16'd1;
  end

  // Miss counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) miss_cnt_q <= '0;
    else        miss_cnt_q <= miss_cnt_d;
  end

  // A table port past NUM_PORT would silently alias after truncation.
  a_port_range : assert property (@(posedge clk) disable iff (!rst_n)
    (s2_load && s1_sop_q && !enc_miss) |-> (int'(enc_port) < NUM_PORT));

  assign tx_tvalid  = tx_valid_q;
  assign tx_tdata   = tx_data_q;
  assign tx_tkeep   = tx_keep_q;
  assign tx_tlast   = tx_last_q;
  assign tx_port_id = tx_port_q;
  assign tx_miss    = tx_miss_q;
  assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_pfvf_route_lookup.sv
// tb_pfvf_route_lookup
// Directed bench: default table and a no-wildcard table driven in lockstep.
module tb_pfvf_route_lookup;
  import pf_vf_mux_pkg::*;

  localparam int DW = 512;

  localparam t_pfvf_rtable_entry C0 =
    '{pf: 3'd0, vf: VF_ANY, vf_active: 1'b0, pfvf_port: 8'd0};
  localparam t_pfvf_rtable_entry C1 =
    '{pf: 3'd1, vf: 11'd0, vf_active: 1'b0, pfvf_port: 8'd1};
  localparam t_pfvf_rtable_entry C2 =
    '{pf: 3'd2, vf: VF_ANY, vf_active: 1'b0, pfvf_port: 8'd1};
  localparam t_pfvf_rtable_entry C3 =
    '{pf: 3'd1, vf: VF_ANY, vf_active: 1'b1, pfvf_port: 8'd0};
  localparam t_pfvf_rtable_entry [3:0] CUST = {C3, C2, C1, C0};

  typedef struct {
    logic [63:0] seq;
    logic [63:0] hdr;
    logic [63:0] keep;
    logic        last;
    logic        dport;
    logic        dmiss;
    logic        cport;
    logic        cmiss;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_tvalid = 1'b0;
  logic [DW-1:0] rx_tdata = '0;
  logic [63:0]   rx_tkeep = '0;
  logic          rx_tlast = 1'b0;
  logic          tx_tready = 1'b1;

  logic          d_rx_tready, c_rx_tready;
  logic          d_tx_tvalid, c_tx_tvalid;
  logic [DW-1:0] d_tx_tdata, c_tx_tdata;
  logic [63:0]   d_tx_tkeep, c_tx_tkeep;
  logic          d_tx_tlast, c_tx_tlast;
  logic [0:0]    d_tx_port_id, c_tx_port_id;
  logic          d_tx_miss, c_tx_miss;
  logic [15:0]   d_miss_cnt, c_miss_cnt;

  int   errs = 0;
  int   checks = 0;
  int   cyc = 0;
  int   sop_acc_cyc = 0;
  logic [63:0] seq = 64'd1;
  bit   rnd_en = 1'b0;
  exp_t exp_q[$];
  int   hs_cyc[$];

  pfvf_route_lookup u_def (
    .clk(clk), .rst_n(rst_n),
    .rx_tvalid(rx_tvalid), .rx_tready(d_rx_tready),
    .rx_tdata(rx_tdata), .rx_tkeep(rx_tkeep), .rx_tlast(rx_tlast),
    .tx_tvalid(d_tx_tvalid), .tx_tready(tx_tready),
    .tx_tdata(d_tx_tdata), .tx_tkeep(d_tx_tkeep), .tx_tlast(d_tx_tlast),
    .tx_port_id(d_tx_port_id), .tx_miss(d_tx_miss), .miss_cnt(d_miss_cnt)
  );

  pfvf_route_lookup #(.PFVF_ROUTING_TABLE(CUST)) u_cust (
    .clk(clk), .rst_n(rst_n),
    .rx_tvalid(rx_tvalid), .rx_tready(c_rx_tready),
    .rx_tdata(rx_tdata), .rx_tkeep(rx_tkeep), .rx_tlast(rx_tlast),
    .tx_tvalid(c_tx_tvalid), .tx_tready(tx_tready),
    .tx_tdata(c_tx_tdata), .tx_tkeep(c_tx_tkeep), .tx_tlast(c_tx_tlast),
    .tx_port_id(c_tx_port_id), .tx_miss(c_tx_miss), .miss_cnt(c_miss_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Hand-derived routes for the default table.
  function automatic logic def_port(input int pf, input int va);
    return (va == 0 && pf == 1);
  endfunction

  // Hand-derived routes for the custom table; miss returned in bit 1.
  function automatic logic [1:0] cust_route(input int pf, input int vf,
                                            input int va);
    if (va == 0) begin
      if (pf == 0) return 2'b00;
      if (pf == 1 && vf == 0) return 2'b01;
      if (pf == 2) return 2'b01;
      return 2'b10;
    end
    if (pf == 1) return 2'b00;
    return 2'b10;
  endfunction

  task automatic send_pkt(input int pf, input int vf, input int va,
                          input int len, input int stop);
    logic [DW-1:0] d;
    logic [1:0]    cr;
    exp_t          e;
    int            n;
    cr = cust_route(pf, vf, va);
    for (int b = 0; b < stop; b++) begin
      d = '0;
      d[511:448] = seq;
      d[63:0]    = ~seq;
      if (b == 0) begin
        d[162:160] = pf[2:0];
        d[173:163] = vf[10:0];
        d[174]     = va[0];
      end else begin
        d[191:128] = {$urandom, $urandom};
      end
      rx_tvalid = 1'b1;
      rx_tdata  = d;
      rx_tkeep  = {seq[31:0], ~seq[31:0]};
      rx_tlast  = (b == len - 1);
      n = 0;
      forever begin
        @(negedge clk);
        if (d_rx_tready) break;
        n++;
        if (n > 500) break;
        @(posedge clk); #1;
      end
      if (n > 500) begin
        chk("rx_timeout", 64'd1, 64'd0);
        rx_tvalid = 1'b0;
        return;
      end
      if (b == 0) sop_acc_cyc = cyc;
      e.seq   = seq;
      e.hdr   = d[191:128];
      e.keep  = {seq[31:0], ~seq[31:0]};
      e.last  = rx_tlast;
      e.dport = def_port(pf, va);
      e.dmiss = 1'b0;
      e.cport = cr[0];
      e.cmiss = cr[1];
      exp_q.push_back(e);
      seq++;
      @(posedge clk); #1;
    end
    rx_tvalid = 1'b0;
    rx_tlast  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || d_tx_tvalid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // Scoreboard plus hold-while-stalled checks, sampled at negedge.
  initial begin
    exp_t        e;
    bit          stall = 1'b0;
    logic [63:0] s_seq;
    logic        s_dp, s_cp, s_cm;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
        continue;
      end
      if (stall) begin
        chk("hold_valid", d_tx_tvalid, 1);
        chk("hold_cvalid", c_tx_tvalid, 1);
        chk("hold_seq", d_tx_tdata[511:448], s_seq);
        chk("hold_dport", d_tx_port_id, s_dp);
        chk("hold_cport", c_tx_port_id, s_cp);
        chk("hold_cmiss", c_tx_miss, s_cm);
      end
      stall = d_tx_tvalid && !tx_tready;
      s_seq = d_tx_tdata[511:448];
      s_dp  = d_tx_port_id;
      s_cp  = c_tx_port_id;
      s_cm  = c_tx_miss;
      if (d_tx_tvalid && tx_tready) begin
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("spurious_beat", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("seq", d_tx_tdata[511:448], e.seq);
          chk("lo", d_tx_tdata[63:0], ~e.seq);
          chk("hdr", d_tx_tdata[191:128], e.hdr);
          chk("keep", d_tx_tkeep, e.keep);
          chk("last", d_tx_tlast, e.last);
          chk("dport", d_tx_port_id, e.dport);
          chk("dmiss", d_tx_miss, e.dmiss);
          chk("cvalid", c_tx_tvalid, 1);
          chk("cseq", c_tx_tdata[511:448], e.seq);
          chk("ckeep", c_tx_tkeep, e.keep);
          chk("clast", c_tx_tlast, e.last);
          chk("cport", c_tx_port_id, e.cport);
          chk("cmiss", c_tx_miss, e.cmiss);
        end
      end
    end
  end

  // Random downstream backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_en) tx_tready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rx_tready", d_rx_tready, 0);
    chk("rst_c_rx_tready", c_rx_tready, 0);
    chk("rst_tx_tvalid", d_tx_tvalid, 0);
    chk("rst_port", d_tx_port_id, 0);
    chk("rst_miss", d_tx_miss, 0);
    chk("rst_cnt", d_miss_cnt, 0);
    chk("rst_c_cnt", c_miss_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_rx_tready", d_rx_tready, 1);
    @(posedge clk); #1;

    // 3-beat PF1 packet, latency 2.
    hs_cyc.delete();
    send_pkt(1, 0, 0, 3, 3);
    drain();
    if (hs_cyc.size() >= 3) chk("latency", 64'(hs_cyc[0] - sop_acc_cyc), 2);
    else chk("pktA_beats", 64'(hs_cyc.size()), 3);

    // Single-beat PF0 then 2-beat PF1, no bubbles.
    hs_cyc.delete();
    send_pkt(0, 0, 0, 1, 1);
    send_pkt(1, 0, 0, 2, 2);
    drain();
    if (hs_cyc.size() == 3) begin
      chk("b2b_gap0", 64'(hs_cyc[1] - hs_cyc[0]), 1);
      chk("b2b_gap1", 64'(hs_cyc[2] - hs_cyc[1]), 1);
    end else chk("b2b_beats", 64'(hs_cyc.size()), 3);

    // PF1/VF5/vf_active=1 hits the trailing wildcard.
    send_pkt(1, 5, 1, 2, 2);
    drain();

    // PF3 misses the custom table.
    send_pkt(3, 0, 0, 1, 1);
    drain();
    chk("miss_cnt_1", c_miss_cnt, 1);
    chk("def_no_miss", d_miss_cnt, 0);

    // Preload to saturation, then one more miss.
    force u_cust.miss_cnt_q = 16'hFFFF;
    @(posedge clk); #1;
    release u_cust.miss_cnt_q;
    send_pkt(3, 0, 0, 2, 2);
    drain();
    chk("miss_cnt_sat", c_miss_cnt, 16'hFFFF);

    // 100 mixed packets with random backpressure.
    rnd_en = 1'b1;
    for (int p = 0; p < 100; p++) begin
      int pf, vf, va, len;
      pf  = $urandom_range(0, 3);
      vf  = ($urandom_range(0, 1) == 1) ? 5 : 0;
      va  = $urandom_range(0, 1);
      len = $urandom_range(1, 4);
      send_pkt(pf, vf, va, len, len);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    rnd_en = 1'b0;
    tx_tready = 1'b1;
    drain();
    chk("rand_drained", 64'(exp_q.size()), 0);
    chk("miss_cnt_hold", c_miss_cnt, 16'hFFFF);
    chk("def_no_miss2", d_miss_cnt, 0);

    // Reset after beat 2 of a 4-beat PF0 packet.
    send_pkt(0, 0, 0, 4, 2);
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_tvalid", d_tx_tvalid, 0);
    chk("mid_rst_rx_tready", d_rx_tready, 0);
    chk("mid_rst_cnt", c_miss_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_pkt(1, 0, 0, 2, 2);
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/pfvf_route_lookup.md
# pfvf_route_lookup

Pipelined AXI-S lookup stage that sits directly in front of the PF/VF MUX in afu_top, on the host-to-AFU (RX) path. It consumes the PF/VF routing table produced by the top-level config package. On the first beat of each TLP it extracts pf_num/vf_num/vf_active from the PCIe SS header, resolves the destination MUX port ID, and forwards every beat of the packet with that port ID attached. Unmatched packets go to port 0, are flagged, and are counted.

## Interface
- NUM_PORT, 2: MUX ports; NID_WIDTH = $clog2(NUM_PORT), minimum 1.
- NUM_RTABLE_ENTRIES, NUM_PORT+2: table depth.
- PFVF_ROUTING_TABLE, none: array of pf_vf_mux_pkg::t_pfvf_rtable_entry {pf, vf, vf_active, pfvf_port}; entry 0 has highest priority.
- DATA_W, 512: AXI-S data width.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- rx_tvalid / rx_tready  in / out  1 / 1  upstream handshake.
- rx_tdata  in  DATA_W  TLP data; header in the first beat.
- rx_tkeep  in  DATA_W/8  byte enables.
- rx_tlast  in  1  end of packet.
- tx_tvalid / tx_tready  out / in  1 / 1  downstream handshake.
- tx_tdata, tx_tkeep, tx_tlast  out  as rx  forwarded unchanged.
- tx_port_id  out  NID_WIDTH  destination port; constant for the whole packet.
- tx_miss  out  1  packet matched no entry; constant for the whole packet.
- miss_cnt  out  16  saturating count of missed packets.

## Operation
- SOP tracking: an in_pkt flag is 0 after reset. The accepted beat with in_pkt=0 is SOP. in_pkt is set on an accepted non-last beat and cleared on an accepted tlast beat.
- Header fields on the SOP beat: pf_num = rx_tdata[162:160], vf_num = rx_tdata[173:163], vf_active = rx_tdata[174].
- Entry match requires all three:
  - entry.pf is all-ones, or entry.pf == pf_num;
  - entry.vf is all-ones, or entry.vf == vf_num;
  - entry.vf_active == vf_active.
- Resolution: the lowest-index matching entry wins, giving port = entry.pfvf_port.
- No match: port = 0 and tx_miss = 1.
- Stage 1 registers beat data, the per-entry match vector, and SOP. Stage 2 encodes the match vector to a port ID on SOP beats and holds that route for the following beats until tlast.
- miss_cnt increments once per missed packet, when its SOP beat leaves stage 2 (tx handshake). It saturates at 16'hFFFF.
- Port ID width: pfvf_port is truncated to NID_WIDTH. A table value ≥ NUM_PORT is a configuration error, flagged by a simulation-only assertion.

## Timing
- Latency: rx handshake to tx_tvalid is 2 cycles.
- Throughput: 1 beat per cycle when tx_tready = 1.
- Each stage is elastic: stage_ready = !stage_valid || next_ready. rx_tready = stage-1 ready.
- While tx_tvalid = 1 and tx_tready = 0, all tx_* outputs hold stable.
- Reset values: tx_tvalid = 0, tx_port_id = 0, tx_miss = 0, miss_cnt = 0, in_pkt = 0, both stage valids = 0.
  - rx_tready = 0 while rst_n = 0, and 1 in the first cycle after release.
  - tx_tdata/tkeep/tlast are don't-care while tx_tvalid = 0.
- Single-beat packet (SOP and tlast on the same beat): routed from its own header; in_pkt stays 0.
- Back-to-back packets: the SOP beat of packet N+1 may follow tlast of N in the next cycle; the route switches exactly on that beat.
- Backpressure mid-packet: the route register is unaffected; the next SOP cannot overwrite it until the held beat drains.
- Reset asserted mid-packet: pipeline contents are dropped and in_pkt cleared. The first beat accepted after reset is treated as SOP.
- miss_cnt at 16'hFFFF plus another miss: stays 16'hFFFF.

## Structure
- The entry typedef (t_pfvf_rtable_entry), the wildcard constant (all-ones), and the header bit offsets belong in pf_vf_mux_pkg.
- One sub-module, pfvf_rtable_match: combinational match vector plus priority encoder, parameterised by table and depth. It is instantiated once, with its output registered in stage 1.

## Test plan
- Default table (PF0→port 0, PF1→port 1, two wildcard defaults), stimulus: one packet PF1/VF0/vf_active=0 of 3 beats. Required: tx_port_id = 1 on all 3 beats, tx_miss = 0, first tx_tvalid 2 cycles after accept.
- Single-beat PF0 packet followed immediately by a 2-beat PF1 packet, tx_tready held at 1. Required: port IDs 0, 1, 1 on consecutive cycles, no bubbles.
- PF1/VF5/vf_active=1. Required: matches the last wildcard entry, tx_port_id = 0, tx_miss = 0.
- Custom table without wildcard entries, send PF3. Required: tx_port_id = 0, tx_miss = 1, miss_cnt = 1. Preload the counter to 16'hFFFF, send another miss: miss_cnt stays 16'hFFFF.
- Random tx_tready toggling across 100 mixed packets. Required: beats in order, no loss, tx_* stable while stalled, port ID constant within each packet.
- Assert rst_n = 0 for 1 cycle after beat 2 of a 4-beat packet, then send a PF1 packet. Required: tx_tvalid = 0 during reset, the next packet is treated as SOP, tx_port_id = 1.
